// File: rtl/restoring_divider_10by5_pkg.sv
// Shared widths and FSM encoding for the 10-by-5 restoring divider.
package restoring_divider_10by5_pkg;
  localparam int DVD_W = 10;
  localparam int DSR_W = 5;
  localparam int MAG_W = 4;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIVIDE, SIGN} state_t;
endpackage

// File: rtl/restoring_divider_10by5_divider_step.sv
// One restoring iteration: shift in the dividend msb, subtract M if it fits.
module divider_step
  import restoring_divider_10by5_pkg::*;
(
  input  logic [MAG_W-1:0] r,
  input  logic             d_msb,
  input  logic [MAG_W-1:0] m,
  output logic [DSR_W-1:0] r_next,
  output logic             q
);
  logic [DSR_W-1:0] t;
  logic [DSR_W-1:0] m_ext;

  // R < M always holds, so only R[3:0] feeds the shift
  assign t      = {r, d_msb};
  assign m_ext  = {1'b0, m};
  assign q      = (t >= m_ext);
  assign r_next = q ? (t - m_ext) : t;
endmodule

// File: rtl/restoring_divider_10by5.sv
// Sequential truncating divider: 10-bit two's-complement by 5-bit sign-magnitude.
module restoring_divider_10by5
  import restoring_divider_10by5_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DVD_W-1:0] dividend_in,
  input  logic [DSR_W-1:0] divisor_in,
  output logic             busy,
  output logic             out_valid,
  output logic [DVD_W-1:0] quotient,
  output logic [DSR_W-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);
  state_t           state;
  logic [DVD_W-1:0] dvd_q;
  logic [DSR_W-1:0] dsr_q;
  logic [DVD_W-1:0] d_reg;
  logic [MAG_W-1:0] m_reg;
  logic [DSR_W-1:0] r_reg;
  logic [CNT_W-1:0] count;
  logic             qneg, rneg, dbz;

  logic [DVD_W-1:0] d_abs;
  logic [DSR_W-1:0] r_next;
  logic             q_bit;
  logic             ovf_case;

  // -512 maps onto 10'h200, which is exactly the unsigned magnitude we want
  assign d_abs    = dvd_q[DVD_W-1] ? (-dvd_q) : dvd_q;
  assign ovf_case = (dvd_q == {1'b1, {(DVD_W-1){1'b0}}}) && dsr_q[DSR_W-1] &&
                    (dsr_q[MAG_W-1:0] == MAG_W'(1));

  divider_step u_step (
    .r      (r_reg[MAG_W-1:0]),
    .d_msb  (d_reg[DVD_W-1]),
    .m      (m_reg),
    .r_next (r_next),
    .q      (q_bit)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      d_reg       <= '0;
      m_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      dbz         <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend_in;
            dsr_q <= divisor_in;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          d_reg <= d_abs;
          m_reg <= dsr_q[MAG_W-1:0];
          r_reg <= '0;
          count <= '0;
          qneg  <= dvd_q[DVD_W-1] ^ dsr_q[DSR_W-1];
          rneg  <= dvd_q[DVD_W-1];
          dbz   <= (dsr_q[MAG_W-1:0] == '0);
          state <= (dsr_q[MAG_W-1:0] == '0) ? SIGN : DIVIDE;
        end
        DIVIDE: begin
          r_reg <= r_next;
          d_reg <= {d_reg[DVD_W-2:0], q_bit};
          count <= count + CNT_W'(1);
          if (count == LAST_CNT) state <= SIGN;
        end
        SIGN: begin
          if (dbz) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            quotient    <= qneg ? (-d_reg) : d_reg;
            remainder   <= rneg ? (-r_reg) : r_reg;
            div_by_zero <= 1'b0;
            overflow    <= ovf_case;
          end
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/restoring_divider_10by5.md
# restoring_divider_10by5

Sequential restoring divider that inverts the team's 4-bit Booth multiplier. It accepts a 10-bit two's-complement dividend (the multiplier's product format) and a 5-bit sign-magnitude divisor (the multiplier's operand format). It returns a 10-bit two's-complement quotient and a 5-bit two's-complement remainder, using truncating division. It sits beside the multiplier in the arithmetic datapath and uses the same `in_valid`/`out_valid` pulse handshake.

## Interface
- No parameters; widths are fixed and listed in the shared package.
- `clock` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: start request; sampled only in IDLE.
- `dividend_in` in 10: two's-complement dividend, range -512..511.
- `divisor_in` in 5: sign-magnitude divisor; bit 4 is the sign, bits 3:0 are the magnitude.
- `busy` out 1: high while a division is in progress.
- `out_valid` out 1: one-cycle pulse marking a new result.
- `quotient` out 10: two's-complement quotient; held until the next result.
- `remainder` out 5: two's-complement remainder with the dividend's sign; held until the next result.
- `div_by_zero` out 1: divisor magnitude was 0; held with the result.
- `overflow` out 1: true quotient +512 is not representable; held with the result.

## Operation
- Every output resets to 0. The FSM resets to IDLE and all internal registers reset to 0.
- IDLE:
  - On `in_valid`=1, capture `dividend_in` and `divisor_in`, then go to LOAD.
  - On `in_valid`=0, stay in IDLE.
- LOAD:
  - D ← |dividend|, 10-bit unsigned; 512 is 10'h200.
  - M ← `divisor_in[3:0]`.
  - R ← 0, count ← 0.
  - qneg ← `dividend[9]` XOR `divisor[4]`; rneg ← `dividend[9]`.
  - If M=0, go to SIGN with the dbz flag set (positive and negative zero both count as zero). Otherwise go to DIVIDE.
- DIVIDE, one quotient bit per cycle, 10 iterations:
  - T = {R[3:0], D[9]}.
  - If T ≥ {1'b0, M}: R ← T−M and q=1. Otherwise: R ← T and q=0.
  - D ← {D[8:0], q}; count ← count+1.
  - After the iteration with count=9, go to SIGN.
  - R < M ≤ 15 always holds, so R[4]=0 and T fits in 5 bits.
- SIGN, registers all outputs:
  - If dbz: `quotient`=0, `remainder`=0, `div_by_zero`=1, `overflow`=0.
  - Otherwise:
    - `quotient` = qneg ? −D : D, 10-bit wrap.
    - `remainder` = rneg ? −R : R, 5-bit.
    - `overflow` = 1 exactly when the dividend is −512, the divisor sign is 1 and M=1; `quotient` is then 10'h200.
  - `out_valid`←1 for one cycle; go to IDLE.
- Negative results with zero magnitude come out as +0; there is no negative zero.
- `in_valid` outside IDLE is ignored. There is no queueing.
- Reset asserted mid-operation aborts immediately. Outputs return to 0, no `out_valid` is generated, and the FSM returns to IDLE.

## Timing
- Call the IDLE edge that samples `in_valid`=1 E0.
- `busy` rises after E0 and falls after E12, in the same cycle that `out_valid` is high.
- Normal division:
  - LOAD runs at E1.
  - DIVIDE runs at E2..E11.
  - SIGN runs at E12.
  - `out_valid` is high for the cycle following E12; latency is 12 edges.
- Divide-by-zero: LOAD at E1, SIGN at E2; `out_valid` follows E2.
- `in_valid`=1 during the `out_valid` cycle is accepted, since the FSM is back in IDLE. Back-to-back throughput is one result per 13 cycles.
- Outputs change only at the SIGN edge or at reset.

## Structure
- Shared package contents:
  - Width constants: DVD_W=10, DSR_W=5, MAG_W=4, CNT_W=4.
  - FSM state encoding: IDLE, LOAD, DIVIDE, SIGN.
- The FSM and counter live in the top module.
- Natural sub-module: `divider_step`. It is combinational and performs one restoring iteration: inputs R, the D msb and M; outputs the next R and q.
- Negation is inline combinational logic; no multi-cycle complement unit is used.

## Test plan
- 100 / 7 (`dividend_in`=10'h064, `divisor_in`=5'b00111) → `quotient`=10'h00E, `remainder`=5'h02, flags 0, `out_valid` 12 edges after E0.
- −100 / 7 (10'h39C, 5'b00111) → `quotient`=10'h3F2, `remainder`=5'h1E. Then 100 / −7 (10'h064, 5'b10111) → `quotient`=10'h3F2, `remainder`=5'h02.
- Divisor 5'b00000, then 5'b10000, each with dividend 10'h05A → `div_by_zero`=1, `quotient`=0, `remainder`=0, `out_valid` 2 edges after E0.
- −512 / −1 (10'h200, 5'b10001) → `quotient`=10'h200, `overflow`=1, `remainder`=0. Then −512 / 1 → `quotient`=10'h200, `overflow`=0.
- `in_valid` pulsed every cycle while `busy` → exactly one result per accepted request; the second request is accepted in the `out_valid` cycle.
- `rst` low at E6 of 100 / 7 → all outputs 0 and no `out_valid`. After release, 45 / 4 → `quotient`=10'h00B, `remainder`=5'h01.
